// File: rtl/zbus_tracer.sv
// zbus_tracer: classifies completed Z80 bus cycles seen through synchronisers, timestamps
// them and buffers them as a triggered ring or a streaming FIFO drained over valid/ready.
//
// state | meaning
// IDLE  | capture off, nothing readable
// ARMED | capturing; ring waits for a trigger match, stream mode runs here
// POST  | ring only: trigger stored, counting down the post-trigger entries
// DONE  | capture frozen, buffer drains oldest first
module zbus_tracer #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int DEPTH_LOG2 = 6,
  parameter int TSW        = 16
) (
  input  logic                         fclk,
  input  logic                         rst_n,
  input  logic [AW-1:0]                z_a,
  input  logic [DW-1:0]                z_di,
  input  logic [DW-1:0]                z_do,
  input  logic                         z_mreq_n,
  input  logic                         z_iorq_n,
  input  logic                         z_rd_n,
  input  logic                         z_wr_n,
  input  logic                         z_m1_n,
  input  logic                         z_rfsh_n,
  input  logic                         mode,
  input  logic [5:0]                   type_mask,
  input  logic [AW-1:0]                trig_addr,
  input  logic [5:0]                   trig_types,
  input  logic [DEPTH_LOG2-1:0]        post_len,
  input  logic                         arm,
  input  logic                         stop,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [3+AW+DW+TSW-1:0]       rd_data,
  output logic [1:0]                   state,
  output logic                         triggered,
  output logic [DEPTH_LOG2:0]          count,
  output logic [7:0]                   ovf_cnt
);
  localparam int EW    = 3 + AW + DW + TSW;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [TSW-1:0]        TS_ONE  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t st, st_nxt;

  logic [5:0]    strb_s1, strb_s2;
  logic [AW-1:0] a_d1, a_d2;
  logic [DW-1:0] di_d1, di_d2, do_d1, do_d2;

  // Strobe synchronisers and the matching two-stage bus delay, order {mreq, iorq, rd, wr, m1, rfsh}
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      strb_s1 <= '1;
      strb_s2 <= '1;
      a_d1    <= '0;
      a_d2    <= '0;
      di_d1   <= '0;
      di_d2   <= '0;
      do_d1   <= '0;
      do_d2   <= '0;
    end else begin
      strb_s1 <= {z_mreq_n, z_iorq_n, z_rd_n, z_wr_n, z_m1_n, z_rfsh_n};
      strb_s2 <= strb_s1;
      a_d1    <= z_a;
      a_d2    <= a_d1;
      di_d1   <= z_di;
      di_d2   <= di_d1;
      do_d1   <= z_do;
      do_d2   <= do_d1;
    end
  end

  logic       mreq, iorq, rd, wr, m1, rfsh;
  logic       act;
  logic [2:0] cyc_type;

  assign {mreq, iorq, rd, wr, m1, rfsh} = ~strb_s2;

  always_comb begin
    act      = 1'b1;
    cyc_type = 3'd0;
    if (iorq && m1)                  cyc_type = 3'd5;
    else if (iorq && wr)             cyc_type = 3'd4;
    else if (iorq && rd)             cyc_type = 3'd3;
    else if (mreq && !rfsh && wr)    cyc_type = 3'd2;
    else if (mreq && !rfsh && rd)    cyc_type = m1 ? 3'd0 : 3'd1;
    else                             act = 1'b0;
  end

  logic          act_q;
  logic [2:0]    hold_type;
  logic [AW-1:0] hold_a;
  logic [DW-1:0] hold_d;
  logic          ev_det;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      act_q     <= 1'b0;
      hold_type <= '0;
      hold_a    <= '0;
      hold_d    <= '0;
    end else begin
      act_q <= act;
      if (act) begin
        hold_type <= cyc_type;
        hold_a    <= a_d2;
        hold_d    <= (cyc_type == 3'd2 || cyc_type == 3'd4) ? do_d2 : di_d2;
      end
    end
  end

  assign ev_det = act_q & ~act;

  logic                  ev_q;
  logic [2:0]            ev_type;
  logic [AW-1:0]         ev_a;
  logic [DW-1:0]         ev_d;
  logic [TSW-1:0]        ev_ts, ts;
  logic                  mode_q;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, remaining;

  // An event caught on the arm edge belongs to the previous run and is dropped
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q    <= 1'b0;
      ev_type <= '0;
      ev_a    <= '0;
      ev_d    <= '0;
      ev_ts   <= '0;
      ts      <= '0;
    end else begin
      ev_q <= ev_det & ~arm;
      ts   <= arm ? '0 : ts + TS_ONE;
      if (ev_det) begin
        ev_type <= hold_type;
        ev_a    <= hold_a;
        ev_d    <= hold_d;
        ev_ts   <= ts;
      end
    end
  end

  logic [7:0] mask_ext, trig_ext;
  logic       full, capture_en, ev_ok, pop, store, drop, overwrite, trig_fire;

  assign mask_ext = {2'b00, type_mask};
  assign trig_ext = {2'b00, trig_types};
  assign full     = count[DEPTH_LOG2];

  always_comb begin
    ev_ok     = ev_q & mask_ext[ev_type] & capture_en & ~stop & ~arm;
    pop       = rd_valid & rd_ready & ~arm;
    store     = mode_q ? (ev_ok & (~full | pop)) : ev_ok;
    drop      = mode_q & ev_ok & full & ~pop;
    overwrite = store & full & ~pop;
    trig_fire = store & ~mode_q & (st == S_ARMED) & (ev_a == trig_addr) & trig_ext[ev_type];
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (arm) begin
      st_nxt = S_ARMED;
    end else begin
      case (st)
        S_ARMED: begin
          if (stop)           st_nxt = S_DONE;
          else if (trig_fire) st_nxt = (post_len == '0) ? S_DONE : S_POST;
        end
        S_POST: begin
          if (stop || (store && remaining == PTR_ONE)) st_nxt = S_DONE;
        end
        default: st_nxt = st;
      endcase
    end
  end

  logic [EW-1:0] mem [DEPTH];

  always_comb begin
    capture_en = (st == S_ARMED) || (st == S_POST);
    rd_valid   = (count != '0) && ((st == S_DONE) || (mode_q && st == S_ARMED));
    rd_data    = rd_valid ? mem[rd_ptr] : '0;
    state      = st;
  end

  always_ff @(posedge fclk) begin
    if (store) mem[wr_ptr] <= {ev_type, ev_a, ev_d, ev_ts};
  end

  // A full ring keeps the newest DEPTH entries: the write slot becomes the new oldest
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf_cnt   <= '0;
      triggered <= 1'b0;
      remaining <= '0;
      mode_q    <= 1'b0;
    end else if (arm) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf_cnt   <= '0;
      triggered <= 1'b0;
      remaining <= '0;
      mode_q    <= mode;
    end else begin
      if (store)             wr_ptr <= wr_ptr + PTR_ONE;
      if (pop || overwrite)  rd_ptr <= rd_ptr + PTR_ONE;
      if (store && !pop && !full)  count <= count + CNT_ONE;
      else if (pop && !store)      count <= count - CNT_ONE;
      if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      if (trig_fire) begin
        triggered <= 1'b1;
        remaining <= post_len;
      end else if (st == S_POST && store) begin
        remaining <= remaining - PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_zbus_tracer.sv
// Directed bench for zbus_tracer: Z80 bus cycles drive the DUT, expected entries go into a
// scoreboard queue and a separate monitor compares each popped entry.
module tb_zbus_tracer;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int DL  = 3;
  localparam int TSW = 16;
  localparam int EW  = 3 + AW + DW + TSW;

  logic fclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 fclk = ~fclk;

  logic [AW-1:0] z_a = '0;
  logic [DW-1:0] z_di = '0, z_do = '0;
  logic z_mreq_n = 1, z_iorq_n = 1, z_rd_n = 1, z_wr_n = 1, z_m1_n = 1, z_rfsh_n = 1;
  logic          mode = 0;
  logic [5:0]    type_mask = 6'h3F;
  logic [AW-1:0] trig_addr = '0;
  logic [5:0]    trig_types = '0;
  logic [DL-1:0] post_len = '0;
  logic          arm = 0, stop = 0, rd_ready = 0;

  logic          rd_valid, triggered;
  logic [EW-1:0] rd_data;
  logic [1:0]    state;
  logic [DL:0]   count;
  logic [7:0]    ovf_cnt;

  logic          b_rd_valid, b_triggered;
  logic [EW-1:0] b_rd_data;
  logic [1:0]    b_state;
  logic [6:0]    b_count;
  logic [7:0]    b_ovf_cnt;

  zbus_tracer #(.AW(AW), .DW(DW), .DEPTH_LOG2(DL), .TSW(TSW)) u_dut (
    .fclk(fclk), .rst_n(rst_n), .z_a(z_a), .z_di(z_di), .z_do(z_do),
    .z_mreq_n(z_mreq_n), .z_iorq_n(z_iorq_n), .z_rd_n(z_rd_n), .z_wr_n(z_wr_n),
    .z_m1_n(z_m1_n), .z_rfsh_n(z_rfsh_n), .mode(mode), .type_mask(type_mask),
    .trig_addr(trig_addr), .trig_types(trig_types), .post_len(post_len),
    .arm(arm), .stop(stop), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .state(state), .triggered(triggered), .count(count), .ovf_cnt(ovf_cnt)
  );

  // Default-depth instance, used where the buffer must hold more than eight entries
  zbus_tracer #(.AW(AW), .DW(DW), .DEPTH_LOG2(6), .TSW(TSW)) u_big (
    .fclk(fclk), .rst_n(rst_n), .z_a(z_a), .z_di(z_di), .z_do(z_do),
    .z_mreq_n(z_mreq_n), .z_iorq_n(z_iorq_n), .z_rd_n(z_rd_n), .z_wr_n(z_wr_n),
    .z_m1_n(z_m1_n), .z_rfsh_n(z_rfsh_n), .mode(mode), .type_mask(type_mask),
    .trig_addr(trig_addr), .trig_types(trig_types), .post_len(6'd0),
    .arm(arm), .stop(stop), .rd_valid(b_rd_valid), .rd_ready(1'b0), .rd_data(b_rd_data),
    .state(b_state), .triggered(b_triggered), .count(b_count), .ovf_cnt(b_ovf_cnt)
  );

  int errors = 0, checks = 0;
  int sb_errors = 0, sb_checks = 0;
  int arm_gen = 0;
  logic [26:0] exp_q[$];

  initial begin : monitor
    logic [26:0]    exp;
    logic [TSW-1:0] last_ts;
    int             seen_gen;
    seen_gen = -1;
    last_ts  = '0;
    forever begin
      @(negedge fclk);
      if (rst_n && rd_valid && rd_ready) begin
        sb_checks++;
        if (exp_q.size() == 0) begin
          sb_errors++;
          $display("FAIL sb_unexpected: got entry %h, none expected", rd_data);
        end else begin
          exp = exp_q.pop_front();
          if (rd_data[EW-1:TSW] !== exp) begin
            sb_errors++;
            $display("FAIL sb_entry: got type/addr/data %h, expected %h", rd_data[EW-1:TSW], exp);
          end
          if (seen_gen == arm_gen) begin
            sb_checks++;
            if (rd_data[TSW-1:0] <= last_ts) begin
              sb_errors++;
              $display("FAIL sb_ts: got ts %0h, expected above %0h", rd_data[TSW-1:0], last_ts);
            end
          end
          seen_gen = arm_gen;
          last_ts  = rd_data[TSW-1:0];
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1;
    tick(1);
    arm = 0;
    arm_gen++;
  endtask

  task automatic pulse_stop();
    stop = 1;
    tick(1);
    stop = 0;
  endtask

  function automatic logic [26:0] ent(input logic [2:0] t, input logic [15:0] a, input logic [7:0] d);
    return {t, a, d};
  endfunction

  // One Z80 cycle of type t; with pop set, rd_ready is held for exactly the store edge
  task automatic bus_cycle(input logic [2:0] t, input logic [15:0] a, input logic [7:0] d,
                           input bit pop);
    z_a = a;
    if (t == 3'd2 || t == 3'd4) begin z_do = d; z_di = 8'hEE; end
    else begin z_di = d; z_do = 8'h55; end
    case (t)
      3'd0: begin z_mreq_n = 0; z_rd_n = 0; z_m1_n = 0; end
      3'd1: begin z_mreq_n = 0; z_rd_n = 0; end
      3'd2: begin z_mreq_n = 0; z_wr_n = 0; end
      3'd3: begin z_iorq_n = 0; z_rd_n = 0; end
      3'd4: begin z_iorq_n = 0; z_wr_n = 0; end
      default: begin z_iorq_n = 0; z_m1_n = 0; end
    endcase
    tick(4);
    {z_mreq_n, z_iorq_n, z_rd_n, z_wr_n, z_m1_n, z_rfsh_n} = 6'h3F;
    tick(3);
    if (pop) rd_ready = 1;
    tick(1);
    if (pop) rd_ready = 0;
    tick(1);
  endtask

  task automatic refresh_cycle(input logic [15:0] a);
    z_a = a;
    z_mreq_n = 0;
    z_rfsh_n = 0;
    tick(4);
    z_mreq_n = 1;
    z_rfsh_n = 1;
    tick(5);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    rd_ready = 1;
    while (count != 0 && n < 100) begin
      tick(1);
      n++;
    end
    rd_ready = 0;
    tick(1);
    check({name, "_count"}, count, 0);
    check({name, "_sbq"}, exp_q.size(), 0);
    check({name, "_valid"}, rd_valid, 0);
  endtask

  initial begin : stim
    tick(3);
    check("rst_state", state, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_trig", triggered, 0);
    check("rst_count", count, 0);
    check("rst_ovf", ovf_cnt, 0);
    rst_n = 1;
    tick(2);

    // Ten fetches, no trigger: deep buffer holds all, depth-8 ring keeps the last eight
    mode = 0; type_mask = 6'h3F; trig_types = 6'h00; trig_addr = 16'h0000; post_len = 0;
    pulse_arm();
    for (int i = 0; i < 10; i++) bus_cycle(3'd0, 16'(i), 8'(i), 0);
    check("fetch10_big_count", b_count, 10);
    check("fetch10_big_state", b_state, 1);
    check("fetch10_big_valid", b_rd_valid, 0);
    check("fetch10_big_data", b_rd_data, 0);
    check("fetch10_ring_count", count, 8);
    check("fetch10_ring_state", state, 1);
    check("fetch10_ring_valid", rd_valid, 0);
    pulse_stop();
    check("fetch10_stop_state", state, 3);
    for (int i = 2; i < 10; i++) exp_q.push_back(ent(3'd0, 16'(i), 8'(i)));
    drain("fetch10_drain");

    // Triggered ring with two post-trigger entries
    trig_addr = 16'h0041; trig_types = 6'h01; post_len = 3'd2;
    pulse_arm();
    for (int a = 16'h30; a <= 16'h50; a++) bus_cycle(3'd0, 16'(a), 8'(a), 0);
    check("ring_state", state, 3);
    check("ring_trig", triggered, 1);
    check("ring_count", count, 8);
    for (int a = 16'h3C; a <= 16'h43; a++) exp_q.push_back(ent(3'd0, 16'(a), 8'(a)));
    drain("ring_drain");

    // post_len 0: IOWR trigger ends the capture on the trigger entry itself
    trig_addr = 16'h00FE; trig_types = 6'h10; post_len = 3'd0;
    pulse_arm();
    check("iowr_arm_trig", triggered, 0);
    bus_cycle(3'd0, 16'h0100, 8'h00, 0);
    bus_cycle(3'd1, 16'h8000, 8'hC3, 0);
    bus_cycle(3'd4, 16'h00FE, 8'h07, 0);
    check("iowr_state", state, 3);
    check("iowr_trig", triggered, 1);
    bus_cycle(3'd0, 16'h0101, 8'h01, 0);
    check("iowr_frozen_count", count, 3);
    exp_q.push_back(ent(3'd0, 16'h0100, 8'h00));
    exp_q.push_back(ent(3'd1, 16'h8000, 8'hC3));
    exp_q.push_back(ent(3'd4, 16'h00FE, 8'h07));
    drain("iowr_drain");

    // Stream mode: overflow counting, then a pop on every store edge
    mode = 1; trig_types = 6'h3F; trig_addr = 16'h0200;
    pulse_arm();
    for (int i = 0; i < 12; i++) begin
      if (i < 8) exp_q.push_back(ent(3'd2, 16'(16'h0200 + i), 8'(8'hA0 + i)));
      bus_cycle(3'd2, 16'(16'h0200 + i), 8'(8'hA0 + i), 0);
    end
    check("stream_count", count, 8);
    check("stream_ovf", ovf_cnt, 4);
    check("stream_state", state, 1);
    check("stream_trig", triggered, 0);
    check("stream_valid", rd_valid, 1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ent(3'd3, 16'(16'h0300 + i), 8'(8'h30 + i)));
      bus_cycle(3'd3, 16'(16'h0300 + i), 8'(8'h30 + i), 1);
      check("stream_popstore_count", count, 8);
    end
    exp_q.push_back(ent(3'd5, 16'h0038, 8'hFF));
    bus_cycle(3'd5, 16'h0038, 8'hFF, 1);
    check("stream_intack_count", count, 8);
    check("stream_ovf_hold", ovf_cnt, 4);
    drain("stream_drain");

    // Refresh never captured; masked opcode fetches ignored
    mode = 0; type_mask = 6'h3E; trig_types = 6'h00;
    pulse_arm();
    for (int i = 0; i < 3; i++) begin
      bus_cycle(3'd0, 16'(16'h0400 + i), 8'h00, 0);
      refresh_cycle(16'(16'h0010 + i));
    end
    check("mask_count", count, 0);
    type_mask = 6'h3F;
    refresh_cycle(16'h0020);
    refresh_cycle(16'h0021);
    check("rfsh_count", count, 0);
    bus_cycle(3'd1, 16'h1234, 8'h9A, 0);
    check("memrd_count", count, 1);
    check("armed_valid", rd_valid, 0);
    check("armed_data", rd_data, 0);
    pulse_stop();
    exp_q.push_back(ent(3'd1, 16'h1234, 8'h9A));
    drain("memrd_drain");

    // Reset in POST, then arm and stop together
    trig_addr = 16'h0500; trig_types = 6'h01; post_len = 3'd5;
    pulse_arm();
    bus_cycle(3'd0, 16'h0500, 8'h11, 0);
    check("post_state", state, 2);
    check("post_count", count, 1);
    rst_n = 0;
    tick(1);
    check("midrst_state", state, 0);
    check("midrst_trig", triggered, 0);
    check("midrst_count", count, 0);
    check("midrst_ovf", ovf_cnt, 0);
    check("midrst_valid", rd_valid, 0);
    check("midrst_data", rd_data, 0);
    rst_n = 1;
    tick(2);
    arm = 1; stop = 1;
    tick(1);
    arm = 0; stop = 0;
    arm_gen++;
    check("armstop_state", state, 1);
    pulse_stop();
    check("stop_state", state, 3);
    check("stop_valid", rd_valid, 0);

    tick(2);
    errors += sb_errors;
    checks += sb_checks;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
